bcd_serial_sub: RTL and testbench

BCD_SERIAL_SUB -- requirements
Module: bcd_serial_sub

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_sub.sv | 21 ++
 rtl/bcd_serial_sub.sv | 140 ++++++++++++++
 tb/tb_bcd_serial_sub.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD subtractor.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        COMP = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor: d = a - b - bin, wrapped into 0..9 with borrow out.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic [DIGIT_W:0] t;

    // Binary difference; the extra top bit is the sign, i.e. the borrow.
    always_comb begin
        t    = {1'b0, a} - {1'b0, b} - (DIGIT_W + 1)'(bin);
        bout = t[DIGIT_W];
        d    = bout ? DIGIT_W'(t + (DIGIT_W + 1)'(10)) : t[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor producing |a-b| with a sign flag and an error flag.
module bcd_serial_sub
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DIGIT_W*NDIG-1:0] a,
    input  logic [DIGIT_W*NDIG-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*NDIG-1:0] diff,
    output logic                    neg,
    output logic                    err
);

    localparam int unsigned W     = DIGIT_W * NDIG;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [IDX_W-1:0]   idx;
    logic               borrow;
    logic [DIGIT_W-1:0] da;
    logic [DIGIT_W-1:0] db;
    logic [DIGIT_W-1:0] dd;
    logic               dbout;
    logic               bad_c;
    logic               last_c;

    // Operand digit mux (COMP negates the partial result) and illegal-digit detect.
    always_comb begin
        da    = '0;
        db    = '0;
        bad_c = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (IDX_W'(i) == idx) begin
                da = (state == COMP) ? '0 : a_q[i*DIGIT_W +: DIGIT_W];
                db = (state == COMP) ? diff[i*DIGIT_W +: DIGIT_W] : b_q[i*DIGIT_W +: DIGIT_W];
            end
            if ((a_q[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) ||
                (b_q[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX))) begin
                bad_c = 1'b1;
            end
        end
    end

    assign last_c = (idx == IDX_W'(NDIG - 1));

    bcd_digit_sub u_digit (
        .a    (da),
        .b    (db),
        .bin  (borrow),
        .d    (dd),
        .bout (dbout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SUB;
            SUB: begin
                if (bad_c)       state_next = FIN;
                else if (last_c) state_next = dbout ? COMP : FIN;
            end
            COMP: if (last_c) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latches, digit index, borrow chain and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        idx    <= '0;
                        borrow <= 1'b0;
                        neg    <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                SUB, COMP: begin
                    if ((state == SUB) && bad_c) begin
                        err  <= 1'b1;
                        diff <= '0;
                        neg  <= 1'b0;
                    end else begin
                        for (int i = 0; i < int'(NDIG); i++) begin
                            if (IDX_W'(i) == idx) diff[i*DIGIT_W +: DIGIT_W] <= dd;
                        end
                        if (last_c) begin
                            idx    <= '0;
                            borrow <= 1'b0;
                            if (state == SUB) neg <= dbout;
                        end else begin
                            idx    <= idx + IDX_W'(1);
                            borrow <= dbout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == FIN);
        end
    end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Bench for bcd_serial_sub: directed cases, reset/ignore cases, random ops on NDIG=4 and NDIG=1.
module tb_bcd_serial_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start1;
    logic [15:0] a4, b4, diff4;
    logic [3:0]  a1, b1, diff1;
    logic        busy4, done4, neg4, err4;
    logic        busy1, done1, neg1, err1;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    bcd_serial_sub #(.NDIG(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .neg(neg4), .err(err4)
    );

    bcd_serial_sub #(.NDIG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .neg(neg1), .err(err1)
    );

    // ---------------- reference model ----------------
    function automatic int bcd_val(input logic [31:0] v, input int nd);
        int r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int x, input int nd);
        logic [31:0] r = '0;
        int y = x;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return r;
    endfunction

    function automatic bit any_bad(input logic [31:0] v, input int nd);
        bit r = 1'b0;
        for (int i = 0; i < nd; i++) if (v[i*4 +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] rnd_digit();
        if ($urandom_range(0, 15) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    // ---------------- stimulus drivers (called at a negedge, return at a negedge) ----------------
    task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input int repulse,
                          output logic [15:0] d, output logic ng, output logic er,
                          output int lat, output int bcnt, output logic idle_ok,
                          output logic [15:0] d_hold);
        a4 = a; b4 = b; start4 = 1'b1;
        lat = 0; bcnt = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            a4 = 16'($urandom); b4 = 16'($urandom);
            start4 = (lat == repulse);
            if (busy4) bcnt++;
            if (done4) break;
        end
        d = diff4; ng = neg4; er = err4;
        start4 = 1'b0;
        @(posedge clk); #1;
        idle_ok = !busy4 && !done4;
        d_hold = diff4;
        @(negedge clk);
    endtask

    task automatic do_op1(input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] d, output logic ng, output logic er,
                          output int lat, output logic idle_ok);
        a1 = a; b1 = b; start1 = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            a1 = 4'($urandom); b1 = 4'($urandom);
            start1 = 1'b0;
            if (done1) break;
        end
        d = diff1; ng = neg1; er = err1;
        @(posedge clk); #1;
        idle_ok = !busy1 && !done1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] d, dh; logic ng, er, ok; int lat, bc;
        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy4, done4, neg4, err4, diff4} !== 20'h0) begin
            n_bad++; $display("FAIL reset4: outputs=%h required 0", {busy4, done4, neg4, err4, diff4});
        end
        n_cmp++;
        if ({busy1, done1, neg1, err1, diff1} !== 8'h0) begin
            n_bad++; $display("FAIL reset1: outputs=%h required 0", {busy1, done1, neg1, err1, diff1});
        end
        // start presented together with reset release: must be taken at the first edge
        rst_n = 1'b1;
        do_op4(16'h0123, 16'h0123, 0, d, ng, er, lat, bc, ok, dh);
        n_cmp++;
        if ({d, ng, er} !== {16'h0000, 1'b0, 1'b0}) begin
            n_bad++; $display("FIRST start result FAIL: diff=%h neg=%b err=%b required 0000/0/0", d, ng, er);
        end
        n_cmp++;
        if (lat !== 5) begin
            n_bad++; $display("FAIL first_start_latency: got %0d required 5", lat);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [4] = '{16'h0123, 16'h0000, 16'h9999, 16'h00A0};
        logic [15:0] tb [4] = '{16'h0456, 16'h9999, 16'h0001, 16'h0001};
        logic [15:0] td [4] = '{16'h0333, 16'h9999, 16'h9998, 16'h0000};
        logic        tn [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        te [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int          tl [4] = '{9, 9, 5, 2};
        logic [15:0] d, dh; logic ng, er, ok; int lat, bc;
        for (int k = 0; k < 4; k++) begin
            do_op4(ta[k], tb[k], 0, d, ng, er, lat, bc, ok, dh);
            n_cmp++;
            if ({d, ng, er} !== {td[k], tn[k], te[k]}) begin
                n_bad++;
                $display("FAIL directed%0d result: diff=%h neg=%b err=%b required %h/%b/%b",
                         k, d, ng, er, td[k], tn[k], te[k]);
            end
            n_cmp++;
            if (lat !== tl[k] || bc !== tl[k]) begin
                n_bad++; $display("FAIL directed%0d timing: latency=%0d busy=%0d required %0d", k, lat, bc, tl[k]);
            end
            n_cmp++;
            if (!ok || dh !== td[k]) begin
                n_bad++; $display("FAIL directed%0d hold: idle=%b diff=%h required 1/%h", k, ok, dh, td[k]);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [15:0] d, dh; logic ng, er, ok; int lat, bc;
        int rp [2] = '{2, 6};
        for (int k = 0; k < 2; k++) begin
            do_op4(16'h0123, 16'h0456, rp[k], d, ng, er, lat, bc, ok, dh);
            n_cmp++;
            if ({d, ng, er} !== {16'h0333, 1'b1, 1'b0} || lat !== 9) begin
                n_bad++;
                $display("FAIL busy_start%0d: diff=%h neg=%b err=%b lat=%0d required 0333/1/0/9", k, d, ng, er, lat);
            end
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL busy_start%0d queued: busy after done=%b required 0", k, busy4);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, dh; logic ng, er, ok; int lat, bc;
        a4 = 16'h0123; b4 = 16'h0456; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy4, done4, neg4, err4, diff4} !== 20'h0) begin
            n_bad++; $display("FAIL reset_mid: outputs=%h required 0", {busy4, done4, neg4, err4, diff4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op4(16'h0500, 16'h0123, 0, d, ng, er, lat, bc, ok, dh);
        n_cmp++;
        if ({d, ng, er} !== {16'h0377, 1'b0, 1'b0} || lat !== 5) begin
            n_bad++; $display("FAIL after_reset: diff=%h neg=%b err=%b lat=%0d required 0377/0/0/5", d, ng, er, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, d, dh, ed; logic ng, er, ok, en, ee; int lat, bc, el;
        logic [3:0] a_s, b_s, d_s, ed_s;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++) begin
                a[i*4 +: 4] = rnd_digit();
                b[i*4 +: 4] = rnd_digit();
            end
            if (k % 10 == 0) b = a;
            ee = any_bad(32'(a), 4) || any_bad(32'(b), 4);
            en = !ee && (bcd_val(32'(a), 4) < bcd_val(32'(b), 4));
            ed = ee ? 16'h0 : 16'(to_bcd((bcd_val(32'(a), 4) > bcd_val(32'(b), 4)) ?
                     bcd_val(32'(a), 4) - bcd_val(32'(b), 4) : bcd_val(32'(b), 4) - bcd_val(32'(a), 4), 4));
            el = ee ? 2 : (en ? 9 : 5);
            do_op4(a, b, 0, d, ng, er, lat, bc, ok, dh);
            n_cmp++;
            if ({d, ng, er} !== {ed, en, ee} || lat !== el || !ok || dh !== ed) begin
                n_bad++;
                $display("FAIL rand4 a=%h b=%h: diff=%h neg=%b err=%b lat=%0d hold=%h required %h/%b/%b/%0d",
                         a, b, d, ng, er, lat, dh, ed, en, ee, el);
            end
        end
        for (int k = 0; k < 30; k++) begin
            a_s = rnd_digit();
            b_s = (k % 8 == 0) ? a_s : rnd_digit();
            ee = (a_s > 4'd9) || (b_s > 4'd9);
            en = !ee && (a_s < b_s);
            ed_s = ee ? 4'h0 : (en ? b_s - a_s : a_s - b_s);
            el = ee ? 2 : (en ? 3 : 2);
            do_op1(a_s, b_s, d_s, ng, er, lat, ok);
            n_cmp++;
            if ({d_s, ng, er} !== {ed_s, en, ee} || lat !== el || !ok) begin
                n_bad++;
                $display("FAIL rand1 a=%h b=%h: diff=%h neg=%b err=%b lat=%0d required %h/%b/%b/%0d",
                         a_s, b_s, d_s, ng, er, lat, ed_s, en, ee, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
